// File: rtl/overflow_logger.sv
// overflow_logger: logs adder carry events as {stamp, sum} into a FWFT FIFO; option OVF_LOGGER_IRQ_EN adds irq
module overflow_logger #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       sum,
    input  logic                   carry,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [WIDTH-1:0]       ev_sum,
    output logic [CNT_W-1:0]       ev_stamp,
    output logic [CNT_W-1:0]       ovf_count,
    output logic                   dropped,
    output logic [$clog2(DEPTH):0] level
`ifdef OVF_LOGGER_IRQ_EN
    ,
    output logic                   irq
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] NEAR = LW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W+WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] level_q, level_d;
    logic [CNT_W-1:0] stamp_q, stamp_d, cnt_q, cnt_d;
    logic dropped_q, dropped_d, push, pop;

    assign ev_valid = level_q != '0;
    assign {ev_stamp, ev_sum} = ev_valid ? mem_q[rd_q] : '0;
    assign ovf_count = cnt_q;
    assign dropped = dropped_q;
    assign level = level_q;

    // next state: a pop frees a slot, so a push into a full FIFO is accepted when popping
    always_comb begin
        pop = ev_valid && ev_ready;
        push = carry && (level_q != FULL || pop);
        stamp_d = stamp_q + 1'b1;
        wr_d = push ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
        level_d = level_q + LW'(push) - LW'(pop);
        cnt_d = (carry && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        dropped_d = dropped_q || (carry && !push);
    end

    // state registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            level_q <= '0;
            stamp_q <= '0;
            cnt_q <= '0;
            dropped_q <= 1'b0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            level_q <= level_d;
            stamp_q <= stamp_d;
            cnt_q <= cnt_d;
            dropped_q <= dropped_d;
        end
    end

    // entry storage captures the stamp before its increment; contents are masked while empty
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_q] <= {stamp_q, sum};
    end

`ifdef OVF_LOGGER_IRQ_EN
    logic irq_q;
    assign irq = irq_q;

    // irq follows the post-edge level/drop state, so it rises and falls on the same edge they change
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else irq_q <= level_d >= NEAR || dropped_d;
    end
`endif
endmodule
